item_sink_fifo: RTL
===================

Name: item_sink_fifo

Overview:
Downstream stage that consumes the 8-bit item stream produced by the pusher and buffers it in a small synchronous FIFO. The consumer drains it with a valid/ready handshake. When the buffer is full, it flags and drops items the producer cannot hold back. Sits between the pusher's item_out and any back-pressuring consumer.

Parameters:
WIDTH, 8, item width in bits; matches pusher item width
DEPTH, 4, number of storage entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  item_in carries a valid item this cycle
item_in  input  WIDTH  item from pusher item_out
in_ready  output  1  FIFO can accept an item this cycle (= !full)
out_valid  output  1  item_out holds the head entry
item_out  output  WIDTH  head entry, first-word-fall-through
out_ready  input  1  consumer takes the head this cycle
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: an item was offered while full

Behaviour:
- Reset (reset==0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, overflow=0, in_ready=1, item_out=0. Storage contents are not reset. Outputs follow immediately, without waiting for a clock edge.
- Push: push = in_valid & in_ready. On the clk edge: mem[wr_ptr]<=item_in, wr_ptr<=wr_ptr+1 (wraps mod DEPTH).
- Pop: pop = out_valid & out_ready. On the clk edge: rd_ptr<=rd_ptr+1 (wraps mod DEPTH).
- count: next = count + push - pop. full = (count==DEPTH), empty = (count==0).
- out_valid = !empty. item_out = mem[rd_ptr] when out_valid, else 0. Both are driven from registers and pointers; there is no combinational path from in_valid/item_in.
- Latency: an item pushed at edge N is visible on item_out with out_valid=1 after edge N (one cycle from in_valid to out_valid). There is no same-cycle bypass.
- in_ready = !full. It depends only on registered state; there is no combinational path from out_ready.
- Full with in_valid=1: the item is dropped, overflow<=1. overflow stays 1 until reset. This holds even if a pop occurs in the same cycle, because in_ready was already 0.
- Simultaneous push and pop when not full and not empty: both occur, count is unchanged, and order is preserved.
- Empty with out_ready=1: no pop and no pointer change.
- Order: strict FIFO. Items leave in acceptance order across pointer wrap-around.
- Reset mid-operation: all in-flight items are discarded. The first item after reset release appears at item_out first.

Optional Feature:
Macro ITEM_SINK_DROP_CNT_EN.
- Defined: adds output port drop_cnt [15:0]. It increments by 1 on each cycle with in_valid=1 and full=1, saturates at 16'hFFFF, and resets to 0. overflow becomes (drop_cnt!=0); behaviour is otherwise identical.
- Not defined: the drop_cnt port and counter are absent. overflow is the sticky bit described above.

Test Plan:
- Reset check: hold reset=0 mid-cycle → count=0, out_valid=0, in_ready=1, overflow=0, item_out=0 without waiting for clk.
- Single item: push 8'h05 one cycle with out_ready=0 → next cycle out_valid=1, item_out=05, count=1. Then out_ready=1 for one cycle → count=0, out_valid=0.
- Fill and overflow (DEPTH=4): out_ready=0, push 1,2,3,4,5,6 on consecutive cycles → count=4, in_ready=0 after the 4th, overflow=1; drain yields exactly 1,2,3,4 and drop_cnt=2 when the macro is defined.
- Streaming: in_valid=1 every cycle with item_in counting 0..19 and out_ready=1 continuously → item_out yields 0..19 in order one cycle late; count stays at 1; no overflow across several pointer wraps.
- Simultaneous push/pop at full: count=4 and in_valid=1 with out_ready=1 → pushed item dropped, overflow=1, count=3.
- Reset mid-stream: with count=3, pulse reset=0 → count=0; the next pushed 8'hAA is the first item_out.

Source files
------------

// File: rtl/item_sink_fifo.sv
// Item sink: small first-word-fall-through FIFO that buffers the pusher's item stream.
// Optional ITEM_SINK_DROP_CNT_EN adds a saturating 16-bit drop counter on port drop_cnt.
module item_sink_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] item_in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] item_out,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow
`ifdef ITEM_SINK_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, empty, push, pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full;
  assign pop   = ~empty & out_ready;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;
  // Gate the head with out_valid so item_out reads 0 whenever nothing is buffered.
  assign item_out  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= item_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

`ifdef ITEM_SINK_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (in_valid && full && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != '0);
`else
  logic overflow_q;

  // Sticky until reset; a same-cycle pop cannot rescue an item offered while full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (in_valid && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule
